i2s_tx_serializer: RTL and testbench

//  Downstream of the audio processing stage. Accepts parallel left/right samples with
//  one-cycle sampling strobes and serialises them to a 48 kHz I2S stream for the codec.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/i2s_slot_mux.sv | 30 +++
 rtl/i2s_tx_serializer.sv | 139 +++++++++++++
 tb/tb_i2s_tx_serializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants for the I2S transmit path: frame geometry, bit-clock divider
// and the counter value at which new samples are loaded.
package audio_pkg;

    localparam int FRAME_LEN    = 256;
    localparam int BCK_DIV      = 4;
    localparam int SLOTS_PER_CH = 32;

    localparam int CNT_W    = $clog2(FRAME_LEN);
    localparam int SLOT_W   = $clog2(SLOTS_PER_CH);
    localparam int SLOT_LSB = $clog2(BCK_DIV);
    localparam int BCK_BIT  = SLOT_LSB - 1;

    localparam logic [CNT_W-1:0] LOAD_CNT = 8'hFF;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

endpackage

// File: rtl/i2s_slot_mux.sv
// Combinational slot-to-bit mapper: picks the channel word and emits its bits MSB first
// in slots 1..SAMPLE_W, zero in slot 0 and in every slot past the sample.
module i2s_slot_mux
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 24
) (
    input  logic                ch,
    input  logic [SLOT_W-1:0]   slot,
    input  logic [SAMPLE_W-1:0] tx_l,
    input  logic [SAMPLE_W-1:0] tx_r,
    output logic                bit_out
);

    logic [SAMPLE_W-1:0] word;
    int                  slot_i;

    always_comb begin
        word    = (ch == CH_RIGHT) ? tx_r : tx_l;
        slot_i  = int'(slot);
        bit_out = 1'b0;
        // Slot s carries word[SAMPLE_W - s]; slot 0 and slots above SAMPLE_W never match.
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (slot_i == SAMPLE_W - i) begin
                bit_out = word[i];
            end
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Double-buffered I2S transmitter: captures strobed L/R samples, loads them at frame end
// and shifts them out MSB first. Build option I2S_MUTE_ON_UNDERRUN_EN mutes a starved channel.
module i2s_tx_serializer
    import audio_pkg::*;
#(
    parameter int IN_W     = 36,
    parameter int SAMPLE_W = 24
) (
    input  logic            MCLK,
    input  logic            RESET,
    input  logic [IN_W-1:0] DATA_LEFT_IN,
    input  logic [IN_W-1:0] DATA_RIGHT_IN,
    input  logic            SAMPLING_POINT_LEFT_IN,
    input  logic            SAMPLING_POINT_RIGHT_IN,
    output logic            BCK_OUT,
    output logic            LRCK_OUT,
    output logic            SDATA_OUT,
    output logic            UNDERRUN_OUT
);

`ifdef I2S_MUTE_ON_UNDERRUN_EN
    localparam bit MUTE_ON_UNDERRUN = 1'b1;
`else
    localparam bit MUTE_ON_UNDERRUN = 1'b0;
`endif

    logic [CNT_W-1:0]    cnt256;
    logic [SAMPLE_W-1:0] pend_l;
    logic [SAMPLE_W-1:0] pend_r;
    logic                pend_vl;
    logic                pend_vr;
    logic [SAMPLE_W-1:0] tx_l;
    logic [SAMPLE_W-1:0] tx_r;

    logic                load;
    logic [SAMPLE_W-1:0] cap_l;
    logic [SAMPLE_W-1:0] cap_r;
    logic [SAMPLE_W-1:0] tx_l_nxt;
    logic [SAMPLE_W-1:0] tx_r_nxt;
    logic                ch;
    logic [SLOT_W-1:0]   slot;
    logic                mux_bit;

    assign load  = (cnt256 == LOAD_CNT);
    assign cap_l = DATA_LEFT_IN[IN_W-1 -: SAMPLE_W];
    assign cap_r = DATA_RIGHT_IN[IN_W-1 -: SAMPLE_W];
    assign ch    = cnt256[CNT_W-1];
    assign slot  = cnt256[SLOT_LSB +: SLOT_W];

    // The low input bits below the transmitted field are intentionally dropped.
    generate
        if (IN_W > SAMPLE_W) begin : g_drop_low
            logic unused_low;
            assign unused_low = ^{DATA_LEFT_IN[IN_W-SAMPLE_W-1:0],
                                  DATA_RIGHT_IN[IN_W-SAMPLE_W-1:0]};
        end
    endgenerate

    // Starved channel either repeats its last word or goes silent.
    always_comb begin
        tx_l_nxt = MUTE_ON_UNDERRUN ? '0 : tx_l;
        tx_r_nxt = MUTE_ON_UNDERRUN ? '0 : tx_r;
        if (pend_vl) begin
            tx_l_nxt = pend_l;
        end
        if (pend_vr) begin
            tx_r_nxt = pend_r;
        end
    end

    // Frame counter
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            cnt256 <= '0;
        end else begin
            cnt256 <= cnt256 + 1'b1;
        end
    end

    // Capture buffer: a strobe coincident with a load still wins the valid flag.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            pend_l  <= '0;
            pend_r  <= '0;
            pend_vl <= 1'b0;
            pend_vr <= 1'b0;
        end else begin
            if (SAMPLING_POINT_LEFT_IN) begin
                pend_l  <= cap_l;
                pend_vl <= 1'b1;
            end else if (load) begin
                pend_vl <= 1'b0;
            end
            if (SAMPLING_POINT_RIGHT_IN) begin
                pend_r  <= cap_r;
                pend_vr <= 1'b1;
            end else if (load) begin
                pend_vr <= 1'b0;
            end
        end
    end

    // Transmit buffer
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            tx_l <= '0;
            tx_r <= '0;
        end else if (load) begin
            tx_l <= tx_l_nxt;
            tx_r <= tx_r_nxt;
        end
    end

    i2s_slot_mux #(
        .SAMPLE_W (SAMPLE_W)
    ) u_slot_mux (
        .ch      (ch),
        .slot    (slot),
        .tx_l    (tx_l),
        .tx_r    (tx_r),
        .bit_out (mux_bit)
    );

    // Output register stage: every output lags cnt256 by one cycle.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            BCK_OUT      <= 1'b0;
            LRCK_OUT     <= 1'b0;
            SDATA_OUT    <= 1'b0;
            UNDERRUN_OUT <= 1'b0;
        end else begin
            BCK_OUT      <= cnt256[BCK_BIT];
            LRCK_OUT     <= cnt256[CNT_W-1];
            SDATA_OUT    <= mux_bit;
            UNDERRUN_OUT <= load & ~(pend_vl & pend_vr);
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: reset, data mapping, underrun, coincident strobe,
// overwrite and clock/edge timing, with hand-computed expectations.
module tb_i2s_tx_serializer;

    localparam int IN_W     = 36;
    localparam int SAMPLE_W = 24;

    logic            MCLK = 1'b0;
    logic            RESET;
    logic [IN_W-1:0] dl;
    logic [IN_W-1:0] dr;
    logic            sl;
    logic            sr;
    logic            bck;
    logic            lrck;
    logic            sdata;
    logic            und;

    int total = 0;
    int bad   = 0;
    int c     = 0;

    int              s_cyc [3];
    logic            s_le  [3];
    logic            s_re  [3];
    logic [IN_W-1:0] s_lv  [3];
    logic [IN_W-1:0] s_rv  [3];

    i2s_tx_serializer #(
        .IN_W     (IN_W),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .MCLK                    (MCLK),
        .RESET                   (RESET),
        .DATA_LEFT_IN            (dl),
        .DATA_RIGHT_IN           (dr),
        .SAMPLING_POINT_LEFT_IN  (sl),
        .SAMPLING_POINT_RIGHT_IN (sr),
        .BCK_OUT                 (bck),
        .LRCK_OUT                (lrck),
        .SDATA_OUT               (sdata),
        .UNDERRUN_OUT            (und)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // c tracks the DUT counter value as it stands after the most recent edge.
    task automatic tick();
        logic r;
        r = RESET;
        @(posedge MCLK);
        #1;
        c = r ? 0 : (c + 1) % 256;
    endtask

    task automatic go_to(input int k);
        while (c != k) tick();
    endtask

    task automatic clear_sched();
        for (int k = 0; k < 3; k++) begin
            s_cyc[k] = -1;
            s_le[k]  = 1'b0;
            s_re[k]  = 1'b0;
            s_lv[k]  = '0;
            s_rv[k]  = '0;
        end
    endtask

    // Reads one full frame starting at c == 0, sampling SDATA on each BCK rise, while
    // applying any scheduled strobes.
    task automatic read_frame(output logic [SAMPLE_W-1:0] l, output logic [SAMPLE_W-1:0] r,
                              output int zbad, output int lrbad,
                              output int un_cnt, output int un_at);
        int slot;
        int ch;
        l = '0; r = '0; zbad = 0; lrbad = 0; un_cnt = 0; un_at = -1;
        for (int i = 0; i < 256; i++) begin
            if (und === 1'b1) begin
                un_cnt++;
                un_at = c;
            end
            if (c % 4 == 3) begin
                slot = (c >> 2) % 32;
                ch   = c >> 7;
                if (lrck !== (ch == 1)) lrbad++;
                if (slot >= 1 && slot <= SAMPLE_W) begin
                    if (ch == 1) r[SAMPLE_W - slot] = sdata;
                    else         l[SAMPLE_W - slot] = sdata;
                end else if (sdata !== 1'b0) begin
                    zbad++;
                end
            end
            sl = 1'b0;
            sr = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (s_cyc[k] == c) begin
                    if (s_le[k]) begin sl = 1'b1; dl = s_lv[k]; end
                    if (s_re[k]) begin sr = 1'b1; dr = s_rv[k]; end
                end
            end
            tick();
        end
        sl = 1'b0;
        sr = 1'b0;
    endtask

    initial begin
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
        int zbad, lrbad, un_cnt, un_at, n;
        int bck_rise, lrck_rise, lrck_high, bad_align, bad_per, bad_lgap, last_b, last_l;
        logic pb, pl, ps;

        RESET = 1'b1; dl = '0; dr = '0; sl = 1'b0; sr = 1'b0;
        clear_sched();
        tick(); tick(); tick();
        chk("init_bck", bck, 0);
        chk("init_lrck", lrck, 0);
        chk("init_sdata", sdata, 0);
        chk("init_und", und, 0);
        RESET = 1'b0;

        // Frame 0: strobe both channels.
        go_to(8'h90);
        dl = 36'h800001000; dr = 36'h7FFFFE000; sl = 1'b1; sr = 1'b1;
        tick();
        sl = 1'b0; sr = 1'b0;
        go_to(0);

        // Frame 1: the data pattern, no strobes -> underrun at next load.
        read_frame(l, r, zbad, lrbad, un_cnt, un_at);
        chk("data_left", l, 24'h800001);
        chk("data_right", r, 24'h7FFFFE);
        chk("data_zero_slots", zbad, 0);
        chk("data_lrck", lrbad, 0);
        chk("data_no_underrun", un_cnt, 0);

        // Frame 2: underrun frame; schedule fresh data and a strobe coincident with the load.
        clear_sched();
        s_cyc[0] = 8'h20; s_le[0] = 1'b1; s_lv[0] = {24'hAAAAAA, 12'hFFF};
                          s_re[0] = 1'b1; s_rv[0] = {24'h555555, 12'hABC};
        s_cyc[1] = 8'hFF; s_le[1] = 1'b1; s_lv[1] = {24'h123456, 12'h000};
        read_frame(l, r, zbad, lrbad, un_cnt, un_at);
`ifdef I2S_MUTE_ON_UNDERRUN_EN
        chk("underrun_left", l, 24'h000000);
        chk("underrun_right", r, 24'h000000);
`else
        chk("underrun_left", l, 24'h800001);
        chk("underrun_right", r, 24'h7FFFFE);
`endif
        chk("underrun_pulses", un_cnt, 1);
        chk("underrun_at", un_at, 0);
        chk("underrun_zero_slots", zbad, 0);

        // Frame 3: old left sample despite coincident strobe; keep right fed.
        clear_sched();
        s_cyc[0] = 8'h10; s_re[0] = 1'b1; s_rv[0] = {24'h654321, 12'h001};
        read_frame(l, r, zbad, lrbad, un_cnt, un_at);
        chk("coinc_old_left", l, 24'hAAAAAA);
        chk("coinc_old_right", r, 24'h555555);
        chk("coinc_no_underrun", un_cnt, 0);

        // Frame 4: coincident value arrives; schedule overwrite pair.
        clear_sched();
        s_cyc[0] = 8'h30; s_le[0] = 1'b1; s_lv[0] = {24'h111111, 12'h000};
                          s_re[0] = 1'b1; s_rv[0] = {24'h0F0F0F, 12'h000};
        s_cyc[1] = 8'h80; s_le[1] = 1'b1; s_lv[1] = {24'h222222, 12'h000};
        read_frame(l, r, zbad, lrbad, un_cnt, un_at);
        chk("coinc_new_left", l, 24'h123456);
        chk("coinc_new_right", r, 24'h654321);
        chk("coinc_next_no_underrun", un_cnt, 0);

        // Frame 5: only the second left strobe survives.
        clear_sched();
        read_frame(l, r, zbad, lrbad, un_cnt, un_at);
        chk("overwrite_left", l, 24'h222222);
        chk("overwrite_right", r, 24'h0F0F0F);
        chk("overwrite_no_underrun", un_cnt, 0);
        chk("overwrite_lrck", lrbad, 0);

        // Timing over 1024 cycles.
        bck_rise = 0; lrck_rise = 0; lrck_high = 0; bad_align = 0; bad_per = 0; bad_lgap = 0;
        last_b = -1; last_l = -1;
        pb = bck; pl = lrck; ps = sdata;
        for (int i = 1; i <= 1024; i++) begin
            tick();
            if (lrck === 1'b1) lrck_high++;
            if (pb === 1'b0 && bck === 1'b1) begin
                bck_rise++;
                if (last_b >= 0 && i - last_b != 4) bad_per++;
                last_b = i;
            end
            if (pl === 1'b0 && lrck === 1'b1) begin
                lrck_rise++;
                if (last_l >= 0 && i - last_l != 256) bad_lgap++;
                last_l = i;
            end
            if ((lrck !== pl || sdata !== ps) && !(pb === 1'b1 && bck === 1'b0)) bad_align++;
            pb = bck; pl = lrck; ps = sdata;
        end
        chk("tim_bck_rises", bck_rise, 256);
        chk("tim_bck_period", bad_per, 0);
        chk("tim_lrck_rises", lrck_rise, 4);
        chk("tim_lrck_period", bad_lgap, 0);
        chk("tim_lrck_duty", lrck_high, 512);
        chk("tim_edge_align", bad_align, 0);

        // Mid-stream reset.
        go_to(8'hA3);
        chk("pre_rst_bck", bck, 1);
        chk("pre_rst_lrck", lrck, 1);
        RESET = 1'b1;
        tick();
        chk("rst_bck", bck, 0);
        chk("rst_lrck", lrck, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_und", und, 0);
        tick(); tick();
        RESET = 1'b0;
        n = 0;
        while (lrck !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("rst_lrck_rise", n, 129);
        go_to(0);
        clear_sched();
        read_frame(l, r, zbad, lrbad, un_cnt, un_at);
        chk("rst_zero_left", l, 24'h000000);
        chk("rst_zero_right", r, 24'h000000);
        chk("rst_underrun", un_cnt, 1);
        chk("rst_underrun_at", un_at, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
